// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between an instruction-fetch
// port (I, read-only) and a load/store port (D, read/write).
// Each access is latched in IDLE, strobed with mem_start in START, then
// completed on a memory response or a timeout in WAIT.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration under
// contention). Without it, D always wins over I.
module mem_arbiter #(
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  output logic                 i_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 d_err,
  output logic                 mem_start,
  output logic                 mem_write_enabled,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_input_data,
  input  logic                 mem_valid,
  input  logic [WORD_SIZE-1:0] mem_output_data,
  input  logic                 mem_err_invalid_address,
  output logic                 busy,
  output logic                 grant
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_arb;
  logic             w_pick_d;
  logic             w_resp;
  logic             w_timeout;
  logic             w_finish;
  logic             w_fin_err;
  logic [WORD_SIZE-1:0] w_fin_rdata;

  // The done pulse blocks arbitration for one cycle so a requester can
  // drop or renew its request before the next grant.
  assign w_arb = (r_state == S_IDLE) && (i_req || d_req) && !(i_done || d_done);

`ifdef MEM_ARB_RR_EN
  logic r_last_grant;

  // Under contention the port that did not win last time gets the grant.
  assign w_pick_d = d_req && (!i_req || !r_last_grant);

  // Remember the most recent winner for the next contention.
  always_ff @(posedge clock) begin
    if (!reset_n)   r_last_grant <= 1'b0;
    else if (w_arb) r_last_grant <= w_pick_d;
  end
`else
  assign w_pick_d = d_req;
`endif

  // Counter holds 0 in the first WAIT cycle, so the last WAIT cycle before a
  // forced completion is at TIMEOUT_CYCLES-2; done then lands exactly
  // TIMEOUT_CYCLES cycles after mem_start.
  assign w_resp      = mem_valid || mem_err_invalid_address;
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 2));
  assign w_finish    = (r_state == S_WAIT) && (w_resp || w_timeout);
  // Completing without mem_valid means an address error or a timeout; error
  // also wins when both response lines are high.
  assign w_fin_err   = mem_err_invalid_address || !mem_valid;
  assign w_fin_rdata = (w_fin_err || mem_write_enabled) ? '0 : mem_output_data;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_arb) w_state_next = S_START;
      S_START: w_state_next = S_WAIT;
      S_WAIT:  if (w_finish) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    mem_start = (r_state == S_START);
    busy      = (r_state != S_IDLE);
  end

  // Request latch, timeout counter and per-port completion registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      grant             <= 1'b0;
      mem_write_enabled <= 1'b0;
      mem_address       <= '0;
      mem_input_data    <= '0;
      r_cnt             <= '0;
      i_done            <= 1'b0;
      i_err             <= 1'b0;
      i_rdata           <= '0;
      d_done            <= 1'b0;
      d_err             <= 1'b0;
      d_rdata           <= '0;
    end else begin
      i_done  <= 1'b0;
      i_err   <= 1'b0;
      i_rdata <= '0;
      d_done  <= 1'b0;
      d_err   <= 1'b0;
      d_rdata <= '0;
      if (w_arb) begin
        grant             <= w_pick_d;
        mem_address       <= w_pick_d ? d_addr : i_addr;
        mem_write_enabled <= w_pick_d && d_we;
        mem_input_data    <= w_pick_d ? d_wdata : '0;
      end
      if (r_state == S_START)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      if (w_finish) begin
        if (grant) begin
          d_done  <= 1'b1;
          d_err   <= w_fin_err;
          d_rdata <= w_fin_rdata;
        end else begin
          i_done  <= 1'b1;
          i_err   <= w_fin_err;
          i_rdata <= w_fin_rdata;
        end
      end
    end
  end

endmodule
